edp_fm_slice_24to29: RTL

- Fast-memory (FM/AC) storage slice for data bits 24-29. Sits directly upstream of the EDP 24-29 datapath slice.
- Holds 8 AC blocks x 16 ACs of 6-bit data plus one stored odd-parity bit per word.
- Writes come from the slice's AR outputs. Registered read data goes back into the datapath AD/AR input muxes.
- Generates the slice partial FM parity and a sticky parity-error flag. Self-initialises all 128 words after reset.

---
 rtl/edp_fm_slice_24to29_if.sv | 33 +++
 rtl/edp_fm_slice_24to29.sv | 125 ++++++++++++
 2 files changed

// File: rtl/edp_fm_slice_24to29_if.sv
// Bus bundle between the FM storage slice for bits 24-29 and its neighbours.
// Handshake: there is no valid/ready pairing on this bus. con_fm_write_18to35_l
// is a per-cycle qualifier sampled at every rising clock edge. fm_ready_h is a
// level that goes high once self-initialisation has finished. Writes presented
// while fm_ready_h is low are discarded.
interface edp_fm_if #(
  parameter int WIDTH = 6
);
  logic [2:0]       apr_fm_block_h;
  logic [3:0]       apr_fm_adr_h;
  logic             con_fm_write_18to35_l;
  logic [WIDTH-1:0] ar_h;
  logic             diag_fm_bad_par_h;
  logic             apr_clr_fm_err_h;
  logic [WIDTH-1:0] fm_h;
  logic             edp_fm_parity_24to29_h;
  logic             fm_par_err_24to29_h;
  logic             fm_ready_h;

  // Storage slice side.
  modport slave (
    input  apr_fm_block_h, apr_fm_adr_h, con_fm_write_18to35_l, ar_h,
           diag_fm_bad_par_h, apr_clr_fm_err_h,
    output fm_h, edp_fm_parity_24to29_h, fm_par_err_24to29_h, fm_ready_h
  );

  // Datapath / control side.
  modport master (
    output apr_fm_block_h, apr_fm_adr_h, con_fm_write_18to35_l, ar_h,
           diag_fm_bad_par_h, apr_clr_fm_err_h,
    input  fm_h, edp_fm_parity_24to29_h, fm_par_err_24to29_h, fm_ready_h
  );
endinterface

// File: rtl/edp_fm_slice_24to29.sv
// Fast-memory storage slice for data bits 24-29.
// The slice holds 8 blocks x 16 ACs of 6-bit words, and each word carries one
// stored odd-parity bit. After reset the slice walks all words to zero with
// good parity. It then serves one read or write per cycle through a single
// registered read port with write-through.
module edp_fm_slice_24to29 #(
  parameter int WIDTH    = 6,
  parameter int ADR_BITS = 7
) (
  input  logic        clk_edp_24_h,
  input  logic        apr_mr_reset_l,
  edp_fm_if.slave     bus,
  output logic        o_dbg_state
);

  localparam int DEPTH = 2 ** ADR_BITS;
  localparam logic [ADR_BITS-1:0] LAST_ADR = ADR_BITS'(DEPTH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADR_BITS-1:0] r_init_cnt;
  logic [WIDTH:0]      r_mem [DEPTH];   // {parity, data}
  logic [WIDTH-1:0]    r_fm;
  logic                r_par;
  logic                r_err;
  logic                r_chk_vld;

  logic [ADR_BITS-1:0] w_addr;
  logic                w_host_wr;
  logic                w_new_par;
  logic [WIDTH:0]      w_rd_word;
  logic                w_par_bad;
  logic                w_we;
  logic [ADR_BITS-1:0] w_wa;
  logic [WIDTH:0]      w_wword;

  assign w_addr    = {bus.apr_fm_block_h, bus.apr_fm_adr_h};
  assign w_host_wr = (r_state == S_RUN) && !bus.con_fm_write_18to35_l;
  // Odd parity of the write data. The diagnostic input flips it to plant a fault.
  assign w_new_par = (~^bus.ar_h) ^ bus.diag_fm_bad_par_h;
  assign w_rd_word = r_mem[w_addr];
  // The read register is checked only after it has been loaded once in RUN.
  assign w_par_bad = r_chk_vld && !(^{r_fm, r_par});

  // Next state and array write port. INIT owns the port until the sweep ends.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_wa        = w_addr;
    w_wword     = {w_new_par, bus.ar_h};
    if (r_state == S_INIT) begin
      w_we    = 1'b1;
      w_wa    = r_init_cnt;
      w_wword = {1'b1, {WIDTH{1'b0}}};
      if (r_init_cnt == LAST_ADR) begin
        w_state_nxt = S_RUN;
      end
    end else begin
      w_we = w_host_wr;
    end
  end

  // State register and the init sweep counter.
  always_ff @(posedge clk_edp_24_h or negedge apr_mr_reset_l) begin
    if (!apr_mr_reset_l) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + ADR_BITS'(1);
      end
    end
  end

  // Storage array. It has no reset because the init sweep defines its contents.
  always_ff @(posedge clk_edp_24_h) begin
    if (w_we) begin
      r_mem[w_wa] <= w_wword;
    end
  end

  // Registered read port. On a write cycle the new word is passed through.
  always_ff @(posedge clk_edp_24_h or negedge apr_mr_reset_l) begin
    if (!apr_mr_reset_l) begin
      r_fm  <= '0;
      r_par <= 1'b1;
    end else if (r_state == S_RUN) begin
      if (w_host_wr) begin
        r_fm  <= bus.ar_h;
        r_par <= w_new_par;
      end else begin
        r_fm  <= w_rd_word[WIDTH-1:0];
        r_par <= w_rd_word[WIDTH];
      end
    end
  end

  // Sticky parity error. A new error takes priority over a clear on the same edge.
  always_ff @(posedge clk_edp_24_h or negedge apr_mr_reset_l) begin
    if (!apr_mr_reset_l) begin
      r_chk_vld <= 1'b0;
      r_err     <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_chk_vld <= 1'b1;
      if (w_par_bad) begin
        r_err <= 1'b1;
      end else if (bus.apr_clr_fm_err_h) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.fm_h                   = r_fm;
  assign bus.edp_fm_parity_24to29_h = r_par;
  assign bus.fm_par_err_24to29_h    = r_err;
  assign bus.fm_ready_h             = (r_state == S_RUN);
  assign o_dbg_state                = r_state;

endmodule
